// File: rtl/contador_arbitro_pkg.sv
// Shared types and constants for the arbitrated up/down step counter.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned NREQ = 2;

endpackage

// File: rtl/contador_arbitro_nucleo.sv
// N-bit step core: counting up wraps at the top, counting down saturates at zero;
// a synchronous clear overrides any step.
module contador_nucleo
  import contador_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  output logic [N-1:0] cnt
);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (up == DIR_UP) begin
        cnt_d = (cnt_q == '1) ? '0 : cnt_q + N'(1);
      end else begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/contador_arbitro.sv
// Round-robin arbiter sharing one step counter between two requesters; each grant
// runs a latched number of steps in a latched direction, then pulses done.
module contador_arbitro
  import contador_pkg::*;
#(
  parameter int unsigned N     = 6,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             clr,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [N-1:0]     out
);

  state_t           state_q, state_d;
  logic             idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             rr_q, rr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             step_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          // rr_q names the requester favoured on a tie
          idx_d   = (req == 2'b11) ? rr_q : req[1];
          dir_d   = dir[idx_d];
          rem_d   = idx_d ? len1 : len0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          step_en = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rr_d    = ~idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      dir_q   <= DIR_DOWN;
      rr_q    <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
    end
  end

  assign gnt  = (state_q == RUN)  ? {idx_q, ~idx_q} : 2'b00;
  assign done = (state_q == DONE) ? {idx_q, ~idx_q} : 2'b00;
  assign busy = (state_q != IDLE);

  contador_nucleo #(
    .N(N)
  ) u_nucleo (
    .clk   (clk),
    .rst_n (reset),
    .en    (step_en),
    .up    (dir_q),
    .clr   (clr),
    .cnt   (out)
  );

endmodule

// File: tb/tb_contador_arbitro.sv
// Self-checking bench for contador_arbitro against a run-level reference model.
module tb_contador_arbitro;

  localparam int unsigned N     = 6;
  localparam int unsigned LEN_W = 8;
  localparam int          MAXV  = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       dir = 2'b00;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic             clr = 1'b0;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [N-1:0]     out;

  int n_checks = 0;
  int n_fail   = 0;
  int model_out = 0;
  int model_rr  = 0;

  contador_arbitro #(.N(N), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .dir  (dir),
    .len0 (len0),
    .len1 (len1),
    .clr  (clr),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic int step_ref(input int o, input bit up);
    if (up) return (o + 1) % MAXV;
    return (o == 0) ? 0 : o - 1;
  endfunction

  // One complete granted run, checked cycle by cycle against the model.
  task automatic do_run(input logic [1:0] r, input logic [1:0] d, input int l0,
                        input int l1, input int clr_step, input bit hold);
    int k;
    int len_k;
    logic [1:0] exp_g;
    k     = (r == 2'b11) ? model_rr : (r[1] ? 1 : 0);
    len_k = (k == 1) ? l1 : l0;
    exp_g = (k == 1) ? 2'b10 : 2'b01;
    req  = r;
    dir  = d;
    len0 = l0[LEN_W-1:0];
    len1 = l1[LEN_W-1:0];
    @(posedge clk); #1;
    n_checks++;
    if (gnt !== exp_g || done !== 2'b00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL grant: gnt=%b done=%b busy=%b, expected gnt=%b done=00 busy=1", gnt, done, busy, exp_g);
    end
    n_checks++;
    if (out !== N'(model_out)) begin
      n_fail++;
      $display("FAIL grant_out: out=%0d expected %0d", out, model_out);
    end
    if (!hold) req = 2'($urandom);
    dir  = 2'($urandom);
    len0 = LEN_W'($urandom);
    len1 = LEN_W'($urandom);
    if (len_k == 0) begin
      @(posedge clk); #1;
    end else begin
      for (int i = 1; i <= len_k; i++) begin
        clr = (i == clr_step);
        @(posedge clk); #1;
        clr = 1'b0;
        model_out = (i == clr_step) ? 0 : step_ref(model_out, d[k]);
        n_checks++;
        if (out !== N'(model_out)) begin
          n_fail++;
          $display("FAIL step %0d: out=%0d expected %0d", i, out, model_out);
        end
        if (i < len_k) begin
          n_checks++;
          if (gnt !== exp_g || done !== 2'b00) begin
            n_fail++;
            $display("FAIL run_hold %0d: gnt=%b done=%b expected gnt=%b done=00", i, gnt, done, exp_g);
          end
        end
      end
    end
    n_checks++;
    if (done !== exp_g || gnt !== 2'b00 || busy !== 1'b1 || out !== N'(model_out)) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b gnt=%b busy=%b out=%0d expected done=%b gnt=00 busy=1 out=%0d",
               done, gnt, busy, out, exp_g, model_out);
    end
    if (!hold) req = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0 || out !== N'(model_out)) begin
      n_fail++;
      $display("FAIL back_idle: done=%b gnt=%b busy=%b out=%0d expected 00/00/0/%0d",
               done, gnt, busy, out, model_out);
    end
    model_rr = 1 - k;
  endtask

  task automatic idle_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_out = 0;
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL idle_clr: out=%0d expected 0", out);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (out !== '0 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%0d gnt=%b done=%b busy=%b expected 0/00/00/0", out, gnt, done, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: out=%0d busy=%b expected 0/0", out, busy);
    end
  endtask

  task automatic test_basic();
    idle_clear();
    do_run(2'b01, 2'b01, 5, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out !== N'(5) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: out=%0d busy=%b expected 5/0", out, busy);
    end
  endtask

  task automatic test_wrap();
    idle_clear();
    do_run(2'b01, 2'b01, 66, 0, 0, 0);
    n_checks++;
    if (out !== N'(2)) begin
      n_fail++;
      $display("FAIL wrap_final: out=%0d expected 2", out);
    end
  endtask

  task automatic test_saturation();
    idle_clear();
    do_run(2'b01, 2'b01, 3, 0, 0, 0);
    do_run(2'b10, 2'b00, 0, 5, 0, 0);
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL saturate_final: out=%0d expected 0", out);
    end
    do_run(2'b10, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_contention();
    idle_clear();
    for (int j = 0; j < 4; j++) begin
      do_run(2'b11, 2'b11, 2, 2, 0, 1);
    end
    req = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_end: gnt=%b busy=%b expected 00/0", gnt, busy);
    end
  endtask

  task automatic test_clr_run();
    idle_clear();
    do_run(2'b01, 2'b01, 10, 0, 0, 0);
    do_run(2'b01, 2'b01, 4, 0, 2, 0);
    n_checks++;
    if (out !== N'(2)) begin
      n_fail++;
      $display("FAIL clr_run_final: out=%0d expected 2", out);
    end
  endtask

  task automatic test_reset_midrun();
    req  = 2'b01;
    dir  = 2'b01;
    len0 = LEN_W'(20);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out !== '0 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: out=%0d gnt=%b done=%b busy=%b expected 0/00/00/0", out, gnt, done, busy);
    end
    model_out = 0;
    model_rr  = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done %0d: done=%b busy=%b expected 00/0", j, done, busy);
      end
    end
    do_run(2'b11, 2'b11, 1, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      do_run(2'($urandom_range(1, 3)), 2'($urandom), int'($urandom_range(0, 70)),
             int'($urandom_range(0, 70)), int'($urandom_range(0, 8)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturation();
    test_contention();
    test_clr_run();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
